// File: rtl/dram_axi_writer.sv
// DRAM write engine: buffers {strb,data} words and issues them
// as AXI4 INCR write bursts, splitting bursts at 4 KB boundaries.
module dram_axi_writer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W+DATA_W/8-1:0] data_in,
  input  logic                       data_we,
  input  logic [ADDR_W+7:0]          ctrl_in,
  input  logic                       ctrl_we,
  output logic                       busy,
  output logic                       done,
  output logic                       err_ovf,
  output logic                       err_resp,
  output logic [ADDR_W-1:0]          m_axi_awaddr,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [DATA_W-1:0]          m_axi_wdata,
  output logic [DATA_W/8-1:0]        m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WORD_W = DATA_W + STRB_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_AW,
    S_W,
    S_B
  } state_t;

  state_t state_q, state_d;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full;
  logic              push;
  logic              pop;
  logic [WORD_W-1:0] head;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        left_q, left_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [7:0]        awlen_q, awlen_d;
  logic [7:0]        beat_q, beat_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              resp_q, resp_d;

  logic [12:0] room;
  logic [10:0] rem4k;
  logic [8:0]  burst;
  logic [7:0]  len_in;

  assign full = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push = data_we & ~full;
  assign pop  = wvalid_q & m_axi_wready;
  assign head = mem[rd_ptr_q];

  assign room   = 13'd4096 - {1'b0, addr_q[11:0]};
  assign rem4k  = room[12:2];
  assign burst  = ({2'b00, left_q} <= rem4k) ? left_q
                                             : rem4k[8:0];
  assign len_in = ctrl_in[ADDR_W+7:ADDR_W];

  // FIFO storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // FIFO pointers/count and burst FSM next state
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    beat_d    = beat_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    resp_d    = resp_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (data_we && full) begin
      ovf_d = 1'b1;
    end
    if (ctrl_we && busy_q) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (ctrl_we) begin
          addr_d  = {ctrl_in[ADDR_W-1:2], 2'b00};
          left_d  = (len_in == 8'd0) ? 9'd256
                                     : {1'b0, len_in};
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q >= CNT_W'(burst)) begin
          awaddr_d  = addr_q;
          awlen_d   = 8'(burst - 9'd1);
          addr_d    = addr_q + ADDR_W'({burst, 2'b00});
          left_d    = left_q - burst;
          beat_d    = 8'd0;
          awvalid_d = 1'b1;
          state_d   = S_AW;
        end
      end
      S_AW: begin
        if (m_axi_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          state_d   = S_W;
        end
      end
      S_W: begin
        if (m_axi_wready) begin
          beat_d = beat_q + 8'd1;
          if (beat_q == awlen_q) begin
            wvalid_d = 1'b0;
            bready_d = 1'b1;
            state_d  = S_B;
          end
        end
      end
      S_B: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp != 2'b00) begin
            resp_d = 1'b1;
          end
          if (left_q == 9'd0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and output registers, async reset aborts any burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      left_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      beat_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      beat_q    <= beat_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      resp_q    <= resp_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err_ovf       = ovf_q;
  assign err_resp      = resp_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'($clog2(STRB_W));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wlast   = wvalid_q & (beat_q == awlen_q);
  assign m_axi_wdata   = wvalid_q ? head[DATA_W-1:0] : '0;
  assign m_axi_wstrb   = wvalid_q ? head[WORD_W-1:DATA_W] : '0;
  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_dram_axi_writer.sv
// Randomized bench for dram_axi_writer against a
// queue-based model of words, bursts and completions.
module tb_dram_axi_writer;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [35:0] data_in = '0;
  logic        data_we = 1'b0;
  logic [39:0] ctrl_in = '0;
  logic        ctrl_we = 1'b0;
  logic        busy, done, err_ovf, err_resp;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  always #5 clk = ~clk;

  dram_axi_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_we       (data_we),
    .ctrl_in       (ctrl_in),
    .ctrl_we       (ctrl_we),
    .busy          (busy),
    .done          (done),
    .err_ovf       (err_ovf),
    .err_resp      (err_resp),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  logic [35:0] mdl_q[$];
  logic [39:0] exp_aw[$];
  int          done_cnt = 0;
  int          wv_cycles = 0;
  int          pending_b = 0;
  int          w_left = 0;
  bit          stall = 0;
  bit          err_once = 0;
  bit          aw_st = 0;
  bit          w_st = 0;
  logic [39:0] aw_hold;
  logic [36:0] w_hold;

  function automatic void plan(logic [7:0] len,
                               logic [31:0] addr);
    int beats;
    longint a;
    beats = (len == 0) ? 256 : int'(len);
    a = longint'(addr & 32'hFFFF_FFFC);
    while (beats > 0) begin
      int room, b;
      room = (4096 - int'(a % 4096)) / 4;
      b = (beats < room) ? beats : room;
      exp_aw.push_back({8'(b - 1), 32'(a)});
      a += 4 * b;
      beats -= b;
    end
  endfunction

  // AXI slave and monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      pending_b = 0;
      w_left = 0;
      aw_st = 0;
      w_st = 0;
      m_axi_awready = 1'b0;
      m_axi_wready = 1'b0;
      m_axi_bvalid = 1'b0;
    end else begin
      m_axi_awready = stall ? ($urandom_range(0, 2) == 0)
                            : 1'b1;
      m_axi_wready = stall ? 1'($urandom_range(0, 1))
                           : 1'b1;
      m_axi_bvalid = (pending_b > 0) &&
                     (stall ? ($urandom_range(0, 1) == 1)
                            : 1'b1);
      m_axi_bresp = err_once ? 2'b10 : 2'b00;
      if (aw_st)
        chk("aw_hold", {m_axi_awvalid, m_axi_awlen,
                        m_axi_awaddr}, {1'b1, aw_hold});
      if (w_st)
        chk("w_hold", {m_axi_wvalid, m_axi_wlast,
                       m_axi_wstrb, m_axi_wdata},
            {1'b1, w_hold});
      aw_st = m_axi_awvalid && !m_axi_awready;
      aw_hold = {m_axi_awlen, m_axi_awaddr};
      w_st = m_axi_wvalid && !m_axi_wready;
      w_hold = {m_axi_wlast, m_axi_wstrb, m_axi_wdata};
      if (m_axi_wvalid) wv_cycles++;
      if (m_axi_awvalid && m_axi_awready) begin
        chk("aw_outstanding", pending_b + w_left, 0);
        chk("aw_expected", exp_aw.size() > 0, 1);
        if (exp_aw.size() > 0) begin
          logic [39:0] e;
          e = exp_aw.pop_front();
          chk("awaddr", m_axi_awaddr, e[31:0]);
          chk("awlen", m_axi_awlen, e[39:32]);
        end
        w_left = int'(m_axi_awlen) + 1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("w_in_burst", w_left > 0, 1);
        chk("wlast", m_axi_wlast, w_left == 1);
        chk("w_model_nonempty", mdl_q.size() > 0, 1);
        if (mdl_q.size() > 0) begin
          logic [35:0] w;
          w = mdl_q.pop_front();
          chk("wdata", {m_axi_wstrb, m_axi_wdata}, w);
        end
        if (w_left == 1) pending_b++;
        if (w_left > 0) w_left--;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        pending_b--;
        err_once = 0;
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    data_we = 1'b0;
    ctrl_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mdl_q.delete();
    exp_aw.delete();
    rst_n = 1'b1;
  endtask

  task automatic push(int n);
    for (int i = 0; i < n; i++) begin
      logic [35:0] w;
      w = {4'($urandom), 32'($urandom)};
      data_in = w;
      data_we = 1'b1;
      if (mdl_q.size() < DEPTH) mdl_q.push_back(w);
      @(posedge clk);
      #1;
    end
    data_we = 1'b0;
  endtask

  task automatic cmd(logic [7:0] len, logic [31:0] addr);
    plan(len, addr);
    ctrl_in = {len, addr};
    ctrl_we = 1'b1;
    @(posedge clk);
    #1;
    ctrl_we = 1'b0;
  endtask

  task automatic wait_done(int start, string tag);
    int t;
    t = 0;
    while (done_cnt == start && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_done"}, done_cnt - start, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_aw_left"}, exp_aw.size(), 0);
  endtask

  initial begin
    int d, s;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {m_axi_awvalid, m_axi_wvalid,
        m_axi_wlast, m_axi_bready, busy, done,
        err_ovf, err_resp}, 0);
    chk("rst_aw", {m_axi_awaddr, m_axi_awlen}, 0);
    chk("awsize", m_axi_awsize, 3'b010);
    chk("awburst", m_axi_awburst, 2'b01);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    push(16);
    d = done_cnt;
    s = wv_cycles;
    cmd(8'd16, 32'h100);
    chk("t1_busy", busy, 1);
    chk("t1_aw_early", m_axi_awvalid, 0);
    @(posedge clk);
    #1;
    chk("t1_aw_latency", m_axi_awvalid, 1);
    wait_done(d, "t1");
    chk("t1_w_b2b", wv_cycles - s, 16);

    push(256);
    d = done_cnt;
    cmd(8'd0, 32'h0);
    wait_done(d, "t2");
    d = done_cnt;
    cmd(8'd1, 32'h40);
    repeat (20) @(posedge clk);
    #1;
    chk("t2_empty_awvalid", m_axi_awvalid, 0);
    chk("t2_empty_aw", exp_aw.size(), 1);
    push(1);
    wait_done(d, "t2b");

    push(8);
    d = done_cnt;
    cmd(8'd8, 32'hFF8);
    wait_done(d, "t3");

    stall = 1;
    push(64);
    d = done_cnt;
    cmd(8'd64, 32'h2000);
    wait_done(d, "t4");
    for (int i = 0; i < 8; i++) begin
      logic [7:0]  len;
      logic [31:0] base, addr;
      len = ($urandom_range(0, 5) == 0)
              ? 8'd0 : 8'($urandom_range(1, 80));
      base = $urandom;
      addr = {base[31:12], 12'hFFF} -
             32'($urandom_range(0, 400));
      push((len == 0) ? 256 : int'(len));
      d = done_cnt;
      cmd(len, addr);
      wait_done(d, "t4r");
    end
    stall = 0;

    chk("t5_ovf_clear", err_ovf, 0);
    chk("t5_resp_clear", err_resp, 0);
    push(32);
    err_once = 1;
    d = done_cnt;
    cmd(8'd32, 32'h3F80);
    repeat (3) @(posedge clk);
    #1;
    ctrl_in = {8'd4, 32'h5000};
    ctrl_we = 1'b1;
    @(posedge clk);
    #1;
    ctrl_we = 1'b0;
    wait_done(d, "t5");
    chk("t5_err_resp", err_resp, 1);
    chk("t5_err_ovf", err_ovf, 1);

    do_reset();
    chk("t6_sticky_rst", {err_ovf, err_resp}, 0);
    push(DEPTH);
    chk("t6_no_ovf_at_depth", err_ovf, 0);
    push(1);
    chk("t6_ovf", err_ovf, 1);
    d = done_cnt;
    cmd(8'd0, 32'h3000);
    wait_done(d, "t6a");
    d = done_cnt;
    cmd(8'd0, 32'h3400);
    wait_done(d, "t6b");
    cmd(8'd1, 32'h10);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_empty_awvalid", m_axi_awvalid, 0);

    do_reset();
    push(16);
    cmd(8'd16, 32'h800);
    begin
      int t;
      t = 0;
      while (!m_axi_wvalid && t < 50) begin
        @(posedge clk);
        #1;
        t++;
      end
    end
    chk("t7_wvalid_seen", m_axi_wvalid, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_flags", {m_axi_awvalid, m_axi_wvalid,
        m_axi_wlast, m_axi_bready, busy, done,
        err_ovf, err_resp}, 0);
    chk("t7_rst_aw", {m_axi_awaddr, m_axi_awlen}, 0);
    chk("t7_rst_w", {m_axi_wstrb, m_axi_wdata}, 0);
    data_we = 1'b0;
    ctrl_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mdl_q.delete();
    exp_aw.delete();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
